// File: rtl/pipe_reg_skid_pkg.sv
// Shared state encoding for the skid-buffered pipeline register.
// The state code doubles as the occupancy count (0, 1 or 2 entries).
package pipe_reg_skid_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [CNT_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_reg_skid_en_reg_n.sv
// Parametrised enable register with asynchronous active-low clear.
// Used for both the main (output) and skid payload registers.
module en_reg_n #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             en,
    input  logic             clr_n
);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer and flush.
// in_ready is registered from the next state, so out_ready never reaches in_ready combinationally.
module pipe_reg_skid
    import pipe_reg_skid_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_in_ready;
    logic               w_accept;
    logic               w_emit;
    logic               w_main_en;
    logic               w_skid_en;
    logic               w_main_sel_skid;
    logic [WIDTH-1:0]   w_main_d;
    logic [WIDTH-1:0]   w_skid_q;

    assign out_valid = (r_state != ST_EMPTY);
    assign in_ready  = r_in_ready;
    assign count     = r_state;
    assign w_accept  = in_valid & r_in_ready;
    assign w_emit    = out_valid & out_ready;
    assign w_main_d  = w_main_sel_skid ? w_skid_q : in_data;

    // in_ready stays low on the first edge after reset release, so nothing is taken before it.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_main_en       = 1'b0;
        w_skid_en       = 1'b0;
        w_main_sel_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_ONE;
                    w_main_en   = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_emit) begin
                    w_main_en   = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_skid_en   = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_emit) begin
                    w_state_nxt     = ST_ONE;
                    w_main_en       = 1'b1;
                    w_main_sel_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        // Flush wins over everything; data enables are dropped so a squashed payload never shows.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_en   = 1'b0;
            w_skid_en   = 1'b0;
        end
    end

    en_reg_n #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .q     (out_data),
        .d     (w_main_d),
        .clk   (clk),
        .en    (w_main_en),
        .clr_n (clr_n)
    );

    en_reg_n #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .q     (w_skid_q),
        .d     (in_data),
        .clk   (clk),
        .en    (w_skid_en),
        .clr_n (clr_n)
    );

endmodule
